cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/dump controller for the 19-bit CPU, used by the bench and by on-board bring-up. It sequences a CPU run: hold reset, then run for a programmable cycle budget or until the CPU halts. It then freezes the CPU and streams every register-file entry out over a valid/ready interface. It replaces fixed-delay reset/run/print sequencing with a parametrised, cycle-exact, handshaked controller.

Parameters:
DATA_WIDTH, 19, register-file word width
NUM_REGS, 8, number of register-file entries dumped (>=1)
ADDR_WIDTH, 3, register address width (2**ADDR_WIDTH >= NUM_REGS)
CYC_WIDTH, 32, width of cycle budget / cycle counter
RESET_CYCLES, 1, cycles cpu_reset is held after start (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin a run (accepted only in IDLE or DONE)
cycle_budget  in  CYC_WIDTH  max run cycles, sampled on accepted start; 0 = unlimited
halt  in  1  CPU halt indication, sampled while cpu_run=1
cpu_reset  out  1  reset to CPU
cpu_run  out  1  CPU clock-enable; CPU state frozen when 0
rf_raddr  out  ADDR_WIDTH  register-file read address
rf_rdata  in  DATA_WIDTH  register-file read data, valid 1 cycle after rf_raddr (synchronous read)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump sink ready
dump_addr  out  ADDR_WIDTH  register index of current beat
dump_data  out  DATA_WIDTH  register value of current beat
done  out  1  run and dump complete
timeout  out  1  run ended on budget, not halt
cycles_run  out  CYC_WIDTH  cycles cpu_run was asserted in last run

Behaviour:
- Reset (sync, active-high, wins over all inputs): state=IDLE; cpu_reset=1, cpu_run=0, dump_valid=0, done=0, timeout=0, cycles_run=0, rf_raddr=0, dump_addr=0, dump_data=0. Reset mid-run or mid-dump aborts; a pending beat is dropped.
- All outputs are registered.
- States: IDLE, RST, RUN, RD, CAP, OUT, DONE.
- IDLE: cpu_reset=1. start=1 -> latch cycle_budget, clear cycles_run/timeout, go RST.
- RST: cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: cpu_reset=0, cpu_run=1. cycles_run increments every RUN cycle and saturates at all-ones.
  - halt=1 -> exit to RD with timeout=0.
  - Else if budget!=0 and this is the budget-th RUN cycle -> exit to RD with timeout=1.
  - halt and budget expiry in the same cycle: halt wins, timeout=0.
  - Result: cpu_run is high for exactly min(budget, halt cycle) cycles, and cycles_run equals that count.
- RD: cpu_run=0, cpu_reset=0, so the register file is preserved. rf_raddr=idx (idx=0 on entry from RUN). Next state CAP.
- CAP: capture rf_rdata into dump_data and idx into dump_addr; assert dump_valid; go OUT.
- OUT: dump_valid held high with dump_data/dump_addr stable until dump_ready=1.
  - On handshake: dump_valid drops next cycle.
  - If idx==NUM_REGS-1 -> DONE; else idx+1 -> RD.
  - Minimum 3 cycles per beat. Beats issue in ascending address order 0..NUM_REGS-1 with no gaps or repeats.
- DONE: done=1, cpu_run=0, cpu_reset=0. cycles_run and timeout hold their values.
  - start=1 -> clear done, latch new budget, go RST.
- start in RST/RUN/RD/CAP/OUT is ignored.
- halt outside RUN is ignored.

Test Plan:
- NUM_REGS=8, RESET_CYCLES=2, budget=5, halt=0 -> cpu_reset high 2 cycles after start; cpu_run high exactly 5 cycles; timeout=1, cycles_run=5; 8 beats with addr 0..7 and data equal to the model reg file; done=1.
- budget=0, halt asserted on 4th RUN cycle -> cpu_run high 4 cycles; cycles_run=4, timeout=0; full dump; done.
- budget=3, halt on 3rd RUN cycle -> halt wins; timeout=0, cycles_run=3.
- dump_ready held low 10 cycles on beat 2, random elsewhere -> dump_valid/dump_data/dump_addr stable while stalled; exactly 8 beats in order; cpu_run stays 0.
- Reset asserted during OUT of beat 3 -> next cycle: IDLE, cpu_reset=1, dump_valid=0, done=0, cycles_run=0. A new start performs a full run and dump from addr 0.
- start pulsed during RUN, then again in DONE -> first pulse ignored (no restart); second pulse clears done and re-runs with the newly latched budget.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/dump controller: holds the CPU in reset, runs it for a cycle budget or until halt, then streams the register file.
// Latency: RESET_CYCLES reset cycles, then the run, then a minimum of 3 cycles per dumped register (RD, CAP, OUT).
// Backpressure: a dump beat stays valid with stable addr/data until dump_ready; the CPU stays frozen meanwhile.
module cpu_run_ctrl #(
    parameter int DATA_WIDTH   = 19,
    parameter int NUM_REGS     = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int CYC_WIDTH    = 32,
    parameter int RESET_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CYC_WIDTH-1:0]  cycle_budget,
    input  logic                  halt,
    output logic                  cpu_reset,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  done,
    output logic                  timeout,
    output logic [CYC_WIDTH-1:0]  cycles_run
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0]        RST_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [CYC_WIDTH-1:0]  CYC_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_RUN, S_RD, S_CAP, S_OUT, S_DONE
    } state_t;

    state_t                state;
    logic [CYC_WIDTH-1:0]  budget;
    logic [ADDR_WIDTH-1:0] idx;
    logic [RCW-1:0]        rst_cnt;
    logic [CYC_WIDTH-1:0]  run_next;
    logic                  budget_hit;

    // run_next is the count including the current RUN cycle, so budget_hit marks the budget-th cycle.
    assign run_next   = (cycles_run == CYC_MAX) ? cycles_run : cycles_run + 1'b1;
    assign budget_hit = (budget != '0) && (run_next == budget);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_reset  <= 1'b1;
            cpu_run    <= 1'b0;
            rf_raddr   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycles_run <= '0;
            budget     <= '0;
            idx        <= '0;
            rst_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        budget     <= cycle_budget;
                        cycles_run <= '0;
                        timeout    <= 1'b0;
                        done       <= 1'b0;
                        cpu_reset  <= 1'b1;
                        rst_cnt    <= '0;
                        state      <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        cpu_reset <= 1'b0;
                        cpu_run   <= 1'b1;
                        state     <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cycles_run <= run_next;
                    // halt takes priority over budget expiry in the same cycle
                    if (halt || budget_hit) begin
                        timeout  <= ~halt;
                        cpu_run  <= 1'b0;
                        idx      <= '0;
                        rf_raddr <= '0;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    dump_data  <= rf_rdata;
                    dump_addr  <= idx;
                    dump_valid <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            rf_raddr <= idx + 1'b1;
                            state    <= S_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: table rows from the test plan, randomized runs against a run-length model, and a mid-dump reset.
module tb_cpu_run_ctrl;

    localparam int DW = 19;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int CW = 32;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] cycle_budget;
    logic          halt;
    logic          cpu_reset;
    logic          cpu_run;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles_run;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
        .CYC_WIDTH(CW), .RESET_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cycle_budget(cycle_budget),
        .halt(halt), .cpu_reset(cpu_reset), .cpu_run(cpu_run),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data),
        .done(done), .timeout(timeout), .cycles_run(cycles_run)
    );

    // Toy CPU register file: scribbled while running, frozen otherwise, synchronous read port.
    logic [DW-1:0] mem [NR];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) mem[i] <= DW'(i * 4099 + 7);
        end else if (cpu_run) begin
            mem[$urandom_range(NR - 1, 0)] <= DW'($urandom);
        end
        rf_rdata <= mem[rf_raddr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Run length is min(budget, halt cycle); budget 0 means unlimited; halt on the budget-th cycle wins.
    function automatic void model(input logic [CW-1:0] bud, input int halt_at,
                                  output int run, output bit to);
        if (halt_at > 0 && (bud == 0 || halt_at <= int'(bud))) begin
            run = halt_at;
            to  = 1'b0;
        end else begin
            run = int'(bud);
            to  = 1'b1;
        end
    endfunction

    task automatic do_run(input logic [CW-1:0] bud, input int halt_at, input int stall_beat,
                          input int stall_len, input bit start_in_run, input bit rand_rdy,
                          input int exp_run, input bit exp_to, input string tag);
        int rst_cnt = 0, run_cnt = 0, first_run = -1, beat = 0, stall = 0;
        bit seen_done = 1'b0, held = 1'b0, hs = 1'b0, rdy;
        logic [AW-1:0] h_addr = '0;
        logic [DW-1:0] h_data = '0;
        start = 1'b1;
        cycle_budget = bud;
        @(posedge clk); #1;
        start = 1'b0;
        cycle_budget = CW'($urandom);
        chk({tag, " reset_after_start"}, 64'(cpu_reset), 64'd1);
        chk({tag, " done_cleared"}, 64'(done), 64'd0);
        for (int n = 1; n <= 3000; n++) begin
            if (cpu_reset) rst_cnt++;
            if (cpu_run) begin
                run_cnt++;
                if (first_run < 0) first_run = n;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (held)
                chk({tag, " stall_hold"}, {dump_valid, dump_addr, dump_data}, {1'b1, h_addr, h_data});
            if (hs)
                chk({tag, " valid_drop"}, 64'(dump_valid), 64'd0);
            hs = 1'b0;
            held = 1'b0;
            halt = cpu_run ? (run_cnt == halt_at) : 1'($urandom);
            start = start_in_run && cpu_run && (run_cnt == 2);
            if (dump_valid) begin
                if (beat == stall_beat && stall < stall_len) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = rand_rdy ? 1'($urandom) : 1'b1;
                end
                if (rdy) begin
                    chk({tag, " beat_addr"}, 64'(dump_addr), 64'(beat));
                    chk({tag, " beat_data"}, 64'(dump_data), 64'(mem[beat % NR]));
                    beat++;
                    hs = 1'b1;
                end else begin
                    held = 1'b1;
                    h_addr = dump_addr;
                    h_data = dump_data;
                end
            end else begin
                rdy = 1'($urandom);
            end
            dump_ready = rdy;
            @(posedge clk); #1;
        end
        halt = 1'b0;
        start = 1'b0;
        dump_ready = 1'b0;
        chk({tag, " done_seen"}, 64'(seen_done), 64'd1);
        chk({tag, " beats"}, 64'(beat), 64'(NR));
        chk({tag, " run_high_cycles"}, 64'(run_cnt), 64'(exp_run));
        chk({tag, " cycles_run"}, 64'(cycles_run), 64'(exp_run));
        chk({tag, " timeout"}, 64'(timeout), 64'(exp_to));
        chk({tag, " reset_len"}, 64'(rst_cnt), 64'(RC));
        chk({tag, " run_start"}, 64'(first_run), 64'(RC + 1));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " done_hold"}, {done, timeout, cycles_run}, {1'b1, exp_to, CW'(exp_run)});
    endtask

    typedef struct {
        logic [CW-1:0] bud;
        int            halt_at;
        int            stall_beat;
        int            stall_len;
        bit            sir;
        bit            rr;
        int            exp_run;
        bit            exp_to;
        string         tag;
    } vec_t;

    vec_t vt [6];

    initial begin
        int r_run;
        bit r_to;
        logic [CW-1:0] r_bud;
        int r_halt;
        bit found;

        vt[0] = '{32'd5, 0, -1, 0,  1'b0, 1'b0, 5, 1'b1, "budget5"};
        vt[1] = '{32'd0, 4, -1, 0,  1'b0, 1'b0, 4, 1'b0, "halt4_unlim"};
        vt[2] = '{32'd3, 3, -1, 0,  1'b0, 1'b0, 3, 1'b0, "halt_wins"};
        vt[3] = '{32'd7, 0, 2,  10, 1'b0, 1'b1, 7, 1'b1, "stall_beat2"};
        vt[4] = '{32'd9, 6, -1, 0,  1'b1, 1'b0, 6, 1'b0, "start_in_run"};
        vt[5] = '{32'd4, 0, -1, 0,  1'b0, 1'b1, 4, 1'b1, "restart_done"};

        reset = 1'b1;
        start = 1'b0;
        halt = 1'b0;
        dump_ready = 1'b0;
        cycle_budget = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst cpu_run", 64'(cpu_run), 64'd0);
        chk("rst dump", {dump_valid, dump_addr, dump_data}, 64'd0);
        chk("rst status", {done, timeout, cycles_run, rf_raddr}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            do_run(vt[i].bud, vt[i].halt_at, vt[i].stall_beat, vt[i].stall_len,
                   vt[i].sir, vt[i].rr, vt[i].exp_run, vt[i].exp_to, vt[i].tag);

        for (int k = 0; k < 6; k++) begin
            r_bud = CW'($urandom_range(12, 0));
            r_halt = int'($urandom_range(15, 0));
            if (r_bud == 0 && r_halt == 0) r_halt = 1;
            model(r_bud, r_halt, r_run, r_to);
            do_run(r_bud, r_halt, int'($urandom_range(NR - 1, 0)), int'($urandom_range(5, 0)),
                   1'b0, 1'b1, r_run, r_to, "random");
        end

        // Reset while beat 3 is waiting in OUT.
        start = 1'b1;
        cycle_budget = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (dump_valid && dump_addr == 3'd3) begin
                found = 1'b1;
                break;
            end
            dump_ready = 1'b1;
            @(posedge clk); #1;
        end
        dump_ready = 1'b0;
        chk("midreset reached_beat3", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset cpu_reset", 64'(cpu_reset), 64'd1);
        chk("midreset outputs", {cpu_run, dump_valid, done, timeout, cycles_run}, 64'd0);
        dump_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        dump_ready = 1'b0;
        chk("midreset no_beat", {dump_valid, cpu_run, cpu_reset}, {1'b0, 1'b0, 1'b1});
        do_run(32'd5, 0, -1, 0, 1'b0, 1'b1, 5, 1'b1, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
